// File: rtl/snap_ctrl_pkg.sv
// snap_ctrl_pkg: shared state encoding and ctrl/status bit positions for the snapshot capture controller
package snap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int CTRL_ARM      = 0;
    localparam int CTRL_TRIG_SEL = 1;
    localparam int CTRL_WE_SEL   = 2;

    localparam int STAT_DONE = 31;
    localparam int STAT_BUSY = 30;

endpackage

// File: rtl/snap_capture_ctrl.sv
// snap_capture_ctrl: arm/trigger controlled single-shot capture of a sample stream into a BRAM
module snap_capture_ctrl
    import snap_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  user_clk,
    input  logic                  user_rst_n,
    input  logic [31:0]           ctrl,
    input  logic                  trig,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_data,
    output logic                  bram_we,
    output logic [31:0]           status
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  arm_prev_q;
    logic                  bram_we_q;
    logic [ADDR_WIDTH-1:0] bram_addr_q;
    logic [DATA_WIDTH-1:0] bram_data_q;
    logic [31:0]           status_q, status_d;
    logic                  wr;
    logic                  arm_edge;
    logic                  accepted;
    logic                  trig_hit;
    logic                  ctrl_unused;

    assign arm_edge    = ctrl[CTRL_ARM] & ~arm_prev_q;
    assign accepted    = ~ctrl[CTRL_WE_SEL] | din_valid;
    assign trig_hit    = ~ctrl[CTRL_TRIG_SEL] | trig;
    assign ctrl_unused = ^ctrl[31:3];

    assign bram_we   = bram_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_data = bram_data_q;
    assign status    = status_q;

    // Next state, write decision and status image; an arm edge overrides everything and suppresses the write
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr       = 1'b0;
        status_d = '0;
        if (arm_edge) begin
            state_d = ST_ARMED;
            count_d = '0;
        end else begin
            case (state_q)
                ST_ARMED:   if (trig_hit) begin
                                state_d = ST_CAPTURE;
                                wr      = accepted;
                            end
                ST_CAPTURE: wr = accepted;
                default:    ;
            endcase
            if (wr) begin
                count_d = count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                if (count_q[ADDR_WIDTH-1:0] == '1) state_d = ST_DONE;
            end
        end
        status_d[STAT_DONE]      = (state_d == ST_DONE);
        status_d[STAT_BUSY]      = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
        status_d[ADDR_WIDTH:0]   = count_d;
    end

    // State, count, arm history and registered BRAM write port / status; address and data hold between writes
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            arm_prev_q  <= 1'b0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_data_q <= '0;
            status_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            arm_prev_q <= ctrl[CTRL_ARM];
            bram_we_q  <= wr;
            status_q   <= status_d;
            if (wr) begin
                bram_addr_q <= count_q[ADDR_WIDTH-1:0];
                bram_data_q <= din;
            end
        end
    end

endmodule
